// File: rtl/host_arb_pkg.sv
// Shared types and width helpers for the host round-robin arbiter.
// Index type covers up to 8 upstream masters.
package host_arb_pkg;

  localparam int unsigned HOST_ARB_MAX_HOSTS = 8;
  localparam int unsigned HOST_IDX_W = $clog2(HOST_ARB_MAX_HOSTS);
  localparam int unsigned TIMEOUT_CNT_W = 16;

  typedef logic [HOST_IDX_W-1:0] host_idx_t;

  // Occupancy counter width for a FIFO of the given depth (0..depth)
  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/host_rr_arbiter_if.sv
// Host-side and bus-side request/response bundle of the arbiter.
// slave: arbiter view, master: environment (masters + bus) view.
interface host_rr_arbiter_if #(
  parameter int unsigned NrHosts      = 2,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
);

  logic [NrHosts-1:0]              host_req_i;
  logic [NrHosts-1:0]              host_gnt_o;
  logic [NrHosts*AddressWidth-1:0] host_addr_i;
  logic [NrHosts-1:0]              host_we_i;
  logic [NrHosts*4-1:0]            host_be_i;
  logic [NrHosts*DataWidth-1:0]    host_wdata_i;
  logic [NrHosts-1:0]              host_rvalid_o;
  logic [DataWidth-1:0]            host_rdata_o;
  logic [NrHosts-1:0]              host_err_o;

  logic                    bus_req_o;
  logic                    bus_gnt_i;
  logic [AddressWidth-1:0] bus_addr_o;
  logic                    bus_we_o;
  logic [3:0]              bus_be_o;
  logic [DataWidth-1:0]    bus_wdata_o;
  logic                    bus_rvalid_i;
  logic [DataWidth-1:0]    bus_rdata_i;
  logic                    bus_err_i;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i,
    input  host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o,
    output host_rdata_o, host_err_o,
    output bus_req_o, bus_addr_o, bus_we_o,
    output bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i,
    input  bus_rdata_i, bus_err_i
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i,
    output host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o,
    input  host_rdata_o, host_err_o,
    input  bus_req_o, bus_addr_o, bus_we_o,
    input  bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i,
    output bus_rdata_i, bus_err_i
  );

endinterface

// File: rtl/host_arb_order_fifo.sv
// Order FIFO of granted master indices, sync reset.
// Wrapping read/write pointers plus an occupancy count.
module host_arb_order_fifo
  import host_arb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  host_idx_t data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output host_idx_t head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = fifo_cnt_w(Depth);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] fifo_cnt_t;

  host_idx_t mem_q [Depth];
  ptr_t      wr_ptr_q, wr_ptr_d;
  ptr_t      rd_ptr_q, rd_ptr_d;
  fifo_cnt_t cnt_q, cnt_d;
  logic      do_push;
  logic      do_pop;

  assign full_o  = (cnt_q == fifo_cnt_t'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + fifo_cnt_t'(1);
      2'b01:   cnt_d = cnt_q - fifo_cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage, no reset needed: entries are only read when counted
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/host_rr_arbiter.sv
// Round-robin arbiter sharing one bus host port among NrHosts masters.
// Optional response watchdog: define HOST_ARB_TIMEOUT_EN.
module host_rr_arbiter
  import host_arb_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  host_rr_arbiter_if.slave io
`ifdef HOST_ARB_TIMEOUT_EN
  ,
  output logic timeout_o
`endif
);

  logic               rst_q;
  logic               block;
  host_idx_t          ptr_q, ptr_d;
  host_idx_t          winner;
  host_idx_t          win_hi, win_lo;
  logic               found_hi;
  logic               any_req;
  logic               bus_req;
  logic               grant;
  logic               fifo_full;
  logic               fifo_empty;
  host_idx_t          fifo_head;
  logic               rsp_pop;
  logic               tmo_hit;
  logic               pop;
  logic [NrHosts-1:0] gnt;
  logic [NrHosts-1:0] rvalid;
  logic [NrHosts-1:0] err;

  // Outputs stay quiet during reset and the cycle after it
  assign block   = rst_i || rst_q;
  assign any_req = |io.host_req_i;
  assign bus_req = any_req && !fifo_full && !block;
  assign grant   = bus_req && io.bus_gnt_i;
  assign rsp_pop = io.bus_rvalid_i && !fifo_empty && !block;
  assign pop     = rsp_pop || tmo_hit;

  // Delayed reset flag
  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
  end

  // Winner: lowest requester at/above ptr, else lowest overall
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (io.host_req_i[h]) begin
        win_lo = host_idx_t'(h);
        if (host_idx_t'(h) >= ptr_q) begin
          win_hi   = host_idx_t'(h);
          found_hi = 1'b1;
        end
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  // Request field mux towards the bus
  always_comb begin
    io.bus_addr_o  = '0;
    io.bus_we_o    = 1'b0;
    io.bus_be_o    = '0;
    io.bus_wdata_o = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (winner == host_idx_t'(h)) begin
        io.bus_addr_o  = io.host_addr_i[h*AddressWidth +: AddressWidth];
        io.bus_we_o    = io.host_we_i[h];
        io.bus_be_o    = io.host_be_i[h*4 +: 4];
        io.bus_wdata_o = io.host_wdata_i[h*DataWidth +: DataWidth];
      end
    end
  end

  // Grant fan-out and response routing to the FIFO head
  always_comb begin
    gnt    = '0;
    rvalid = '0;
    err    = '0;
    for (int h = 0; h < NrHosts; h++) begin
      gnt[h]    = grant && (winner == host_idx_t'(h));
      rvalid[h] = pop && (fifo_head == host_idx_t'(h));
      err[h]    = rvalid[h] && (tmo_hit || io.bus_err_i);
    end
  end

  assign io.bus_req_o     = bus_req;
  assign io.host_gnt_o    = gnt;
  assign io.host_rvalid_o = rvalid;
  assign io.host_err_o    = err;
  assign io.host_rdata_o  = (block || tmo_hit) ? '0 : io.bus_rdata_i;

  // Pointer moves past the winner on every grant
  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (winner == host_idx_t'(NrHosts - 1)) ? '0
            : winner + host_idx_t'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  host_arb_order_fifo #(
    .Depth(MaxOutstanding)
  ) u_order_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (grant),
    .data_i (winner),
    .pop_i  (pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

`ifdef HOST_ARB_TIMEOUT_EN
  typedef logic [TIMEOUT_CNT_W-1:0] wdog_t;

  wdog_t wdog_q, wdog_d;
  logic  tmo_q, tmo_d;

  // A real response in the same cycle wins over the timeout
  assign tmo_hit = !fifo_empty && !io.bus_rvalid_i && !block
                && (wdog_q == wdog_t'(TimeoutCycles - 1));

  // Watchdog counts waiting cycles, restarts on every pop
  always_comb begin
    wdog_d = (pop || fifo_empty) ? '0 : wdog_q + wdog_t'(1);
    tmo_d  = tmo_q || tmo_hit;
  end

  // Watchdog and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign tmo_hit = 1'b0;
`endif

`ifndef SYNTHESIS
  a_rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(io.bus_rvalid_i && fifo_empty)
  );
`endif

endmodule

// File: tb/tb_host_rr_arbiter.sv
// Self-checking bench for host_rr_arbiter.
// Define HOST_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_host_rr_arbiter;

  localparam int unsigned NH = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst;
`ifdef HOST_ARB_TIMEOUT_EN
  logic timeout;
`endif

  int checks = 0;
  int errors = 0;
  logic [NH-1:0] exp_q [$];

  host_rr_arbiter_if #(
    .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)
  ) bif ();

  host_rr_arbiter #(
    .NrHosts(NH),
    .DataWidth(DW),
    .AddressWidth(AW),
    .MaxOutstanding(4),
    .TimeoutCycles(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .io   (bif)
`ifdef HOST_ARB_TIMEOUT_EN
    ,
    .timeout_o(timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.host_req_i   = '0;
    bif.host_we_i    = '0;
    bif.bus_gnt_i    = 1'b0;
    bif.bus_rvalid_i = 1'b0;
    bif.bus_err_i    = 1'b0;
    bif.bus_rdata_i  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [NH-1:0] e;
    idle();
    rst = 1'b1;
    bif.host_req_i  = '1;
    bif.bus_gnt_i   = 1'b1;
    bif.bus_rdata_i = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bif.host_gnt_o, bif.host_rvalid_o, bif.host_err_o,
           bif.bus_req_o} !== '0 || bif.host_rdata_o !== '0) begin
        errors++;
        $display("FAIL reset_outs c=%0d gnt=%b rv=%b err=%b req=%b rdata=%h want all 0",
                 c, bif.host_gnt_o, bif.host_rvalid_o, bif.host_err_o,
                 bif.bus_req_o, bif.host_rdata_o);
      end
      tick();
      if (c == 2) rst = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (bif.host_gnt_o !== 2'b01 || bif.bus_req_o !== 1'b1 ||
        bif.bus_addr_o !== 32'h1000_0000) begin
      errors++;
      $display("FAIL reset_first_gnt gnt=%b req=%b addr=%h want 01 1 10000000",
               bif.host_gnt_o, bif.bus_req_o, bif.bus_addr_o);
    end
    exp_q.push_back(2'b01);
    tick();
    idle();
    bif.bus_rvalid_i = 1'b1;
    bif.bus_rdata_i  = 32'h0000_1234;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bif.host_rvalid_o !== e || bif.host_rdata_o !== 32'h1234 ||
        bif.host_err_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_rsp rv=%b rdata=%h err=%b want %b 1234 00",
               bif.host_rvalid_o, bif.host_rdata_o, bif.host_err_o, e);
    end
    tick();
    idle();
  endtask

  task automatic test_fairness();
    logic [NH-1:0] e;
    logic [NH-1:0] g;
    int cnt0;
    int cnt1;
    cnt0 = 0;
    cnt1 = 0;
    do_reset();
    bif.host_req_i = 2'b11;
    bif.bus_gnt_i  = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k == 8) begin
        bif.host_req_i = '0;
        bif.bus_gnt_i  = 1'b0;
      end
      bif.bus_rvalid_i = (k > 0);
      bif.bus_rdata_i  = 32'h100 + 32'(k);
      @(negedge clk);
      if (k > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bif.host_rvalid_o !== e ||
            bif.host_rdata_o !== 32'h100 + 32'(k)) begin
          errors++;
          $display("FAIL fair_rsp k=%0d rv=%b rdata=%h want %b %h",
                   k, bif.host_rvalid_o, bif.host_rdata_o, e,
                   32'h100 + 32'(k));
        end
      end
      if (k < 8) begin
        g = (k % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (bif.host_gnt_o !== g) begin
          errors++;
          $display("FAIL fair_gnt k=%0d gnt=%b want %b",
                   k, bif.host_gnt_o, g);
        end
        exp_q.push_back(g);
      end
      cnt0 += int'(bif.host_rvalid_o[0]);
      cnt1 += int'(bif.host_rvalid_o[1]);
      tick();
    end
    checks++;
    if (cnt0 != 4 || cnt1 != 4) begin
      errors++;
      $display("FAIL fair_count rv0=%0d rv1=%0d want 4 4", cnt0, cnt1);
    end
    idle();
  endtask

  task automatic test_routing();
    logic [NH-1:0] e;
    bif.host_req_i = 2'b10;
    bif.host_addr_i[AW +: AW] = 32'h0005_0000;
    bif.bus_gnt_i  = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.host_gnt_o !== 2'b10 || bif.bus_addr_o !== 32'h0005_0000 ||
        bif.bus_we_o !== 1'b0) begin
      errors++;
      $display("FAIL route_gnt1 gnt=%b addr=%h we=%b want 10 00050000 0",
               bif.host_gnt_o, bif.bus_addr_o, bif.bus_we_o);
    end
    exp_q.push_back(2'b10);
    tick();
    bif.host_req_i = 2'b01;
    bif.host_addr_i[0 +: AW] = 32'h0010_0000;
    @(negedge clk);
    checks++;
    if (bif.host_gnt_o !== 2'b01 || bif.bus_addr_o !== 32'h0010_0000) begin
      errors++;
      $display("FAIL route_gnt0 gnt=%b addr=%h want 01 00100000",
               bif.host_gnt_o, bif.bus_addr_o);
    end
    exp_q.push_back(2'b01);
    tick();
    idle();
    bif.bus_rvalid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bif.bus_rdata_i = (k == 0) ? 32'hAAAA : 32'hBBBB;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bif.host_rvalid_o !== e || bif.host_rdata_o !== bif.bus_rdata_i ||
          bif.host_err_o !== 2'b00) begin
        errors++;
        $display("FAIL route_rsp k=%0d rv=%b rdata=%h err=%b want %b %h 00",
                 k, bif.host_rvalid_o, bif.host_rdata_o, bif.host_err_o,
                 e, bif.bus_rdata_i);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [NH-1:0] e;
    bif.host_req_i = 2'b01;
    bif.bus_gnt_i  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bif.host_gnt_o !== 2'b01 || bif.bus_req_o !== 1'b1) begin
        errors++;
        $display("FAIL bp_fill k=%0d gnt=%b req=%b want 01 1",
                 k, bif.host_gnt_o, bif.bus_req_o);
      end
      exp_q.push_back(2'b01);
      tick();
    end
    @(negedge clk);
    checks++;
    if (bif.host_gnt_o !== 2'b00 || bif.bus_req_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_full gnt=%b req=%b want 00 0",
               bif.host_gnt_o, bif.bus_req_o);
    end
    tick();
    bif.bus_rvalid_i = 1'b1;
    bif.bus_rdata_i  = 32'h0BAD_0001;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bif.host_rvalid_o !== e || bif.host_gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL bp_pop rv=%b gnt=%b want %b 00",
               bif.host_rvalid_o, bif.host_gnt_o, e);
    end
    tick();
    bif.bus_rvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bif.host_gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL bp_regrant gnt=%b want 01", bif.host_gnt_o);
    end
    exp_q.push_back(2'b01);
    tick();
    idle();
    bif.bus_rvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bif.bus_rdata_i = 32'h0BAD_0010 + 32'(k);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bif.host_rvalid_o !== e) begin
        errors++;
        $display("FAIL bp_drain k=%0d rv=%b want %b",
                 k, bif.host_rvalid_o, e);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_error();
    logic [NH-1:0] e;
    bif.host_req_i = 2'b01;
    bif.host_we_i  = 2'b01;
    bif.host_addr_i[0 +: AW]  = 32'hF000_0000;
    bif.host_wdata_i[0 +: DW] = 32'hCAFE_F00D;
    bif.host_be_i[0 +: 4]     = 4'b0110;
    bif.bus_gnt_i  = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.host_gnt_o !== 2'b01 || bif.bus_we_o !== 1'b1 ||
        bif.bus_addr_o !== 32'hF000_0000 ||
        bif.bus_wdata_o !== 32'hCAFE_F00D || bif.bus_be_o !== 4'b0110) begin
      errors++;
      $display("FAIL err_req gnt=%b we=%b addr=%h wd=%h be=%b want 01 1 f0000000 cafef00d 0110",
               bif.host_gnt_o, bif.bus_we_o, bif.bus_addr_o,
               bif.bus_wdata_o, bif.bus_be_o);
    end
    exp_q.push_back(2'b01);
    tick();
    idle();
    bif.bus_rvalid_i = 1'b1;
    bif.bus_err_i    = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bif.host_rvalid_o !== e || bif.host_err_o !== e) begin
      errors++;
      $display("FAIL err_rsp rv=%b err=%b want %b %b",
               bif.host_rvalid_o, bif.host_err_o, e, e);
    end
    tick();
    idle();
  endtask

`ifdef HOST_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    int first;
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle timeout=%b want 0", timeout);
    end
    bif.host_req_i = 2'b10;
    bif.bus_gnt_i  = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.host_gnt_o !== 2'b10) begin
      errors++;
      $display("FAIL tmo_gnt gnt=%b want 10", bif.host_gnt_o);
    end
    tick();
    idle();
    bif.bus_rdata_i = 32'h5555_5555;
    seen  = 0;
    first = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bif.host_rvalid_o !== 2'b00) begin
        seen++;
        if (seen == 1) begin
          first = c;
          checks++;
          if (c != 16 || bif.host_rvalid_o !== 2'b10 ||
              bif.host_err_o !== 2'b10 || bif.host_rdata_o !== '0) begin
            errors++;
            $display("FAIL tmo_rsp cyc=%0d rv=%b err=%b rdata=%h want 16 10 10 0",
                     c, bif.host_rvalid_o, bif.host_err_o, bif.host_rdata_o);
          end
        end
      end
      tick();
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL tmo_count rvalids=%0d first=%0d want 1", seen, first);
    end
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_flag timeout=%b want 1", timeout);
    end
    idle();
  endtask
`endif

  initial begin
    rst = 1'b1;
    bif.host_addr_i  = {32'h2000_0000, 32'h1000_0000};
    bif.host_be_i    = '1;
    bif.host_wdata_i = {32'h2222_2222, 32'h1111_1111};
    idle();
    test_reset();
    test_fairness();
    test_routing();
    test_backpressure();
    test_error();
`ifdef HOST_ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drained left=%0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
